// File: rtl/dbus_ctrl_if.sv
// Data-bus request/response types, load/store opcodes and the bus interface between dbus_ctrl and the memory port.
// master drives dreq and samples dresp; slave is the memory-side view.
package dbus_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2b;
endpackage

interface dbus_if;
   import dbus_pkg::*;
   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_ctrl.sv
// Memory-stage data-bus controller: one access in flight, min 2 cycles valid->rdata_valid, stall holds the pipe until DONE.
// Load alignment/extension is done here only when DBUS_CTRL_LOAD_EXT_EN is defined; otherwise raw bus data is returned.
module dbus_ctrl
   import dbus_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  dbus_req_t   m_req,
   input  logic [5:0]  m_op,
   input  logic        adv,
   dbus_if.master      bus,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   dbus_req_t   lat_req;
   logic [5:0]  lat_op;
   logic [31:0] load_data;

`ifdef DBUS_CTRL_LOAD_EXT_EN
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      case (lat_req.addr[1:0])
         2'd0:    sel_byte = bus.dresp.data[7:0];
         2'd1:    sel_byte = bus.dresp.data[15:8];
         2'd2:    sel_byte = bus.dresp.data[23:16];
         default: sel_byte = bus.dresp.data[31:24];
      endcase
      sel_half = lat_req.addr[1] ? bus.dresp.data[31:16] : bus.dresp.data[15:0];
      case (lat_op)
         OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
         OP_LBU:  load_data = {24'd0, sel_byte};
         OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
         OP_LHU:  load_data = {16'd0, sel_half};
         OP_LW:   load_data = bus.dresp.data;
         default: load_data = '0;
      endcase
   end
`else
   always_comb begin
      case (lat_op)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: load_data = bus.dresp.data;
         default:                             load_data = '0;
      endcase
   end
`endif

   // The instruction is released only once its access has completed.
   assign stall = m_req.valid && (state != DONE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         lat_req     <= '0;
         lat_op      <= '0;
         bus.dreq    <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.dreq    <= '0;
               rdata_valid <= 1'b0;
               if (m_req.valid) begin
                  lat_req  <= m_req;
                  lat_op   <= m_op;
                  bus.dreq <= m_req;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (bus.dresp.addr_ok) begin
                  bus.dreq <= '0;
                  if (bus.dresp.data_ok) begin
                     rdata       <= load_data;
                     rdata_valid <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  // Re-drive from the latched copy so later m_req changes cannot leak onto the bus.
                  bus.dreq <= lat_req;
               end
            end
            WAIT: begin
               bus.dreq <= '0;
               if (bus.dresp.data_ok) begin
                  rdata       <= load_data;
                  rdata_valid <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               bus.dreq <= '0;
               if (adv) begin
                  rdata_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
